// File: rtl/io_bus_router.sv
// Registered address decoder / transaction sequencer between the core data port and RAM/IO slaves.
// Optional wait-state timeout is compiled in with `define IO_BUS_ROUTER_TIMEOUT_EN.
module io_bus_router #(
  parameter int unsigned N_IO           = 3,
  parameter logic [32:0] IO_BASE_PAGE   = 33'h100000001,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [63:0]          cpu_addr,
  input  logic [63:0]          cpu_wdata,
  output logic                 cpu_ack,
  output logic                 cpu_err,
  output logic [63:0]          cpu_rdata,
  output logic [63:0]          bus_addr,
  output logic                 bus_we,
  output logic [63:0]          bus_wdata,
  output logic                 mem_sel,
  input  logic                 mem_ack,
  input  logic [63:0]          mem_rdata,
  output logic [N_IO-1:0]      io_sel,
  input  logic [N_IO-1:0]      io_ack,
  input  logic [64*N_IO-1:0]   io_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_ack, r_err, r_we, r_mem_sel;
  logic [63:0]       r_rdata, r_addr, r_wdata;
  logic [N_IO-1:0]   r_io_sel;

  logic              w_canon, w_dec_err, w_sel_ack, w_to_expire;
  logic [32:0]       w_page_off;
  logic [N_IO-1:0]   w_io_dec;
  logic [63:0]       w_io_data, w_sel_data;

  // Page offset wraps as 33-bit unsigned, so pages below the base fall out of range too.
  always_comb begin
    w_canon    = (cpu_addr[63:47] == {17{cpu_addr[46]}});
    w_page_off = cpu_addr[46:14] - IO_BASE_PAGE;
    w_io_dec   = '0;
    for (int unsigned i = 0; i < N_IO; i++) begin
      w_io_dec[i] = cpu_addr[46] && (w_page_off == 33'(i));
    end
    w_dec_err  = !w_canon || (cpu_addr[46] && !(|w_io_dec));
  end

  always_comb begin
    w_io_data = '0;
    for (int unsigned i = 0; i < N_IO; i++) begin
      if (r_io_sel[i]) w_io_data = w_io_data | io_rdata[64*i +: 64];
    end
    w_sel_ack  = (r_mem_sel & mem_ack) | (|(r_io_sel & io_ack));
    w_sel_data = r_mem_sel ? mem_rdata : w_io_data;
  end

`ifdef IO_BUS_ROUTER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_to_cnt;

  assign w_to_expire = (r_to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Clearing while idle is equivalent to clearing on WAIT entry: WAIT is only entered from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_to_cnt <= '0;
    end else if (!w_sel_ack && (r_to_cnt != CW'(TIMEOUT_CYCLES))) begin
      r_to_cnt <= r_to_cnt + CW'(1);
    end
  end
`else
  assign w_to_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (cpu_req) w_state_nxt = w_dec_err ? S_RESP : S_WAIT;
      S_WAIT:  if (w_sel_ack || w_to_expire) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Ack in the expiring cycle takes priority over the timeout error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_mem_sel <= 1'b0;
      r_io_sel  <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            if (w_dec_err) begin
              r_ack   <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end else begin
              r_mem_sel <= !cpu_addr[46];
              r_io_sel  <= w_io_dec;
            end
          end
        end
        S_WAIT: begin
          if (w_sel_ack) begin
            r_ack     <= 1'b1;
            r_rdata   <= w_sel_data;
            r_mem_sel <= 1'b0;
            r_io_sel  <= '0;
          end else if (w_to_expire) begin
            r_ack     <= 1'b1;
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_mem_sel <= 1'b0;
            r_io_sel  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_ack   = r_ack;
  assign cpu_err   = r_err;
  assign cpu_rdata = r_rdata;
  assign bus_addr  = r_addr;
  assign bus_we    = r_we;
  assign bus_wdata = r_wdata;
  assign mem_sel   = r_mem_sel;
  assign io_sel    = r_io_sel;

endmodule

// File: tb/tb_io_bus_router.sv
// Self-checking bench for io_bus_router: directed test-plan cases plus randomized transactions
// against a map-level reference model; honours IO_BUS_ROUTER_TIMEOUT_EN.
module tb_io_bus_router;

  localparam int unsigned N_IO    = 3;
  localparam logic [32:0] IO_BASE = 33'h100000001;
  localparam int          T       = 4;
`ifdef IO_BUS_ROUTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cpu_req, cpu_we;
  logic [63:0]          cpu_addr, cpu_wdata;
  logic                 cpu_ack, cpu_err;
  logic [63:0]          cpu_rdata, bus_addr, bus_wdata;
  logic                 bus_we, mem_sel, mem_ack;
  logic [63:0]          mem_rdata;
  logic [N_IO-1:0]      io_sel, io_ack;
  logic [64*N_IO-1:0]   io_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] last_rdata = '0;

  io_bus_router #(
    .N_IO           (N_IO),
    .IO_BASE_PAGE   (IO_BASE),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
    .mem_sel(mem_sel), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .io_sel(io_sel), .io_ack(io_ack), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference map: -1 error, 0 RAM, 1+i IO slave i.
  function automatic int ref_target(input logic [63:0] a);
    logic [32:0] pg;
    longint      idx;
    if (a[63:47] != {17{a[46]}}) return -1;
    if (!a[46]) return 0;
    pg  = a[46:14];
    idx = longint'(pg) - longint'(IO_BASE);
    if (idx >= 0 && idx < longint'(N_IO)) return 1 + int'(idx);
    return -1;
  endfunction

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    logic [32:0] pg;
    a = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0, 5: a[63:46] = '0;
      1: begin
        pg = IO_BASE + 33'($urandom_range(0, N_IO - 1));
        a  = {17'h1ffff, pg, a[13:0]};
      end
      2: begin
        pg = ($urandom_range(0, 1) == 0) ? IO_BASE - 33'd1 : IO_BASE + 33'(N_IO);
        a  = {17'h1ffff, pg, a[13:0]};
      end
      3: if (a[63:47] == {17{a[46]}}) a[60] = ~a[60];
      default: a[63:46] = '1;
    endcase
    return a;
  endfunction

  task automatic scramble_rdata();
    mem_rdata = {$urandom, $urandom};
    for (int i = 0; i < int'(N_IO); i++) io_rdata[64*i +: 64] = {$urandom, $urandom};
  endtask

  // One transaction: target acks d cycles after select rises (if it is a mapped target).
  task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input int d, input logic [63:0] rd, input bit stray, input bit rst_mid);
    int          tgt;
    logic [N_IO:0] exp_sel;
    bit          done;
    tgt     = ref_target(addr);
    exp_sel = '0;
    if (tgt >= 0) exp_sel[tgt] = 1'b1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    scramble_rdata();
    tick();
    chk("bus_addr", bus_addr, addr);
    chk("bus_we", 64'(bus_we), 64'(we));
    chk("bus_wdata", bus_wdata, wdata);
    cpu_addr = {$urandom, $urandom}; cpu_wdata = {$urandom, $urandom}; cpu_we = ~we;
    if (tgt < 0) begin
      chk("err_ack", 64'(cpu_ack), 64'd1);
      chk("err_err", 64'(cpu_err), 64'd1);
      chk("err_rdata", cpu_rdata, 64'd0);
      chk("err_nosel", 64'({io_sel, mem_sel}), 64'd0);
      last_rdata = '0;
    end else begin
      done = 1'b0;
      for (int w = 0; w <= d && !done; w++) begin
        chk("wait_sel", 64'({io_sel, mem_sel}), 64'(exp_sel));
        chk("wait_noack", 64'(cpu_ack), 64'd0);
        chk("wait_addr_held", bus_addr, addr);
        if (rst_mid) begin
          rst = 1'b1; cpu_req = 1'b0;
          tick();
          rst = 1'b0;
          chk("rst_sel", 64'({io_sel, mem_sel}), 64'd0);
          chk("rst_ack", 64'(cpu_ack), 64'd0);
          chk("rst_rdata", cpu_rdata, 64'd0);
          chk("rst_bus_addr", bus_addr, 64'd0);
          last_rdata = '0;
          return;
        end
        scramble_rdata();
        mem_ack = 1'b0; io_ack = '0;
        if (stray) begin
          {io_ack, mem_ack} = (w == 0) ? ~exp_sel : ((N_IO+1)'($urandom) & ~exp_sel);
        end
        if (w == d) begin
          if (tgt == 0) begin
            mem_ack = 1'b1; mem_rdata = rd;
          end else begin
            io_ack[tgt-1] = 1'b1; io_rdata[64*(tgt-1) +: 64] = rd;
          end
        end
        tick();
        mem_ack = 1'b0; io_ack = '0;
        if (w == d) begin
          chk("done_ack", 64'(cpu_ack), 64'd1);
          chk("done_err", 64'(cpu_err), 64'd0);
          chk("done_rdata", cpu_rdata, rd);
          chk("done_sel", 64'({io_sel, mem_sel}), 64'd0);
          last_rdata = rd;
          done = 1'b1;
        end else if (TO_EN && w == T - 1) begin
          chk("to_ack", 64'(cpu_ack), 64'd1);
          chk("to_err", 64'(cpu_err), 64'd1);
          chk("to_rdata", cpu_rdata, 64'd0);
          chk("to_sel", 64'({io_sel, mem_sel}), 64'd0);
          last_rdata = '0;
          done = 1'b1;
        end
      end
    end
    cpu_req = 1'b0;
    tick();
    chk("idle_noack", 64'(cpu_ack), 64'd0);
    chk("idle_rdata_hold", cpu_rdata, last_rdata);
    chk("idle_nosel", 64'({io_sel, mem_sel}), 64'd0);
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; io_ack = '0; io_rdata = '0;
    repeat (3) tick();
    chk("rst_state_ack", 64'(cpu_ack), 64'd0);
    chk("rst_state_err", 64'(cpu_err), 64'd0);
    chk("rst_state_sel", 64'({io_sel, mem_sel}), 64'd0);
    chk("rst_state_rdata", cpu_rdata, 64'd0);
    chk("rst_state_bus", bus_addr | bus_wdata | 64'(bus_we), 64'd0);
    rst = 1'b0;
    tick();

    txn(1'b0, 64'h0000_0000_0000_1000, 64'h0, 1, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
    txn(1'b1, 64'hFFFF_C000_0000_8000, 64'h1234_5678_9ABC_DEF0, 0, 64'h55, 1'b0, 1'b0);
    txn(1'b0, 64'h0000_4000_0000_4000, 64'h0, 0, 64'h0, 1'b0, 1'b0);
    txn(1'b0, 64'hFFFF_C000_0000_0000, 64'h0, 0, 64'h0, 1'b0, 1'b0);
    if (TO_EN) begin
      txn(1'b0, 64'hFFFF_C000_0000_4000, 64'h0, 10, 64'hA5A5, 1'b0, 1'b0);
      txn(1'b0, 64'hFFFF_C000_0000_4000, 64'h0, T - 1, 64'hC3C3_0001, 1'b0, 1'b0);
    end else begin
      txn(1'b0, 64'hFFFF_C000_0000_4000, 64'h0, 299, 64'h0BAD_F00D, 1'b0, 1'b0);
    end
    txn(1'b0, 64'hFFFF_C000_0000_4000, 64'h0, 5, 64'h0, 1'b0, 1'b1);
    txn(1'b0, 64'h0000_0000_0000_2000, 64'h0, 2, 64'hFEED_FACE_0000_0001, 1'b0, 1'b0);
    txn(1'b0, 64'hFFFF_C000_0000_4000, 64'h0, 2, 64'h7777_0000_2222, 1'b1, 1'b0);

    for (int n = 0; n < 150; n++) begin
      txn(1'($urandom), rand_addr(), {$urandom, $urandom}, int'($urandom_range(0, 6)),
          {$urandom, $urandom}, 1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_bus_router.md
# io_bus_router

Registered address decoder and transaction sequencer between the Raisin64 core's data port and its memory and IO slaves. It checks canonical form, decodes the upper half of the map into a parametrised number of IO pages, and drives a one-hot select. It then waits for the selected slave's acknowledge and returns read data, or a bus error for unmapped or non-responding targets. It is the successor to the purely combinational map decode.

## Interface

Parameters:
- `N_IO`, 3: number of IO pages; page i occupies addr[46:14] == IO_BASE_PAGE + i.
- `IO_BASE_PAGE`, 33'h100000001: page number of IO slave 0.
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles before a bus error (only with timeout compiled in).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `cpu_req`  in  1  transaction request; held until `cpu_ack`, dropped the cycle after
- `cpu_we`  in  1  1 = write
- `cpu_addr`  in  64  byte address
- `cpu_wdata`  in  64  write data
- `cpu_ack`  out  1  one-cycle completion strobe
- `cpu_err`  out  1  bus error, valid with `cpu_ack`
- `cpu_rdata`  out  64  read data, valid with `cpu_ack`
- `bus_addr` / `bus_we` / `bus_wdata`  out  64/1/64  latched request, broadcast to all slaves
- `mem_sel`  out  1  RAM select (lower half)
- `mem_ack`  in  1  RAM acknowledge
- `mem_rdata`  in  64  RAM read data
- `io_sel`  out  N_IO  one-hot IO select
- `io_ack`  in  N_IO  IO acknowledges
- `io_rdata`  in  64*N_IO  IO read data; slave i at [64*i+63:64*i]

## Operation

- **Canonical:** `cpu_addr[63:47]` all equal `cpu_addr[46]`. Otherwise the request is an error.
- **Decode:**
  - addr[46]=0 targets RAM.
  - addr[46]=1 targets IO slave i when addr[46:14] − IO_BASE_PAGE = i < N_IO. Subtraction is 33-bit unsigned.
  - Any other upper-half page is unmapped and is an error.
- **FSM states:** IDLE, WAIT, RESP.
  - **IDLE:** when `cpu_req`=1, latch addr/we/wdata into `bus_*` and decode.
    - Error: go to RESP with err=1. No select is ever asserted.
    - Otherwise: assert the target's select bit and go to WAIT.
  - **WAIT:** select held. When the selected slave's ack=1, latch its rdata (writes latch too), drop the select and go to RESP with err=0.
    - Acks from unselected slaves are ignored.
  - **RESP:** `cpu_ack`=1 for exactly one cycle, then go to IDLE.
- `cpu_rdata` holds its last value until the next completion. On error it is 0.
- `cpu_req` is sampled only in IDLE. Changes to `cpu_*` inputs in WAIT or RESP have no effect.
- At most one select bit (across `mem_sel` and `io_sel`) is high at any time.

## Timing

- **Reset** (any state, including mid-WAIT):
  - state = IDLE.
  - `cpu_ack`, `cpu_err`, `mem_sel`, `io_sel` = 0.
  - `cpu_rdata`, `bus_addr`, `bus_wdata` = 0; `bus_we` = 0.
  - Timeout counter = 0.
  - Any in-flight transaction is abandoned silently.
- All outputs are registered; there is no combinational input-to-output path.
- **Latency, error:** req sampled in cycle 0 → `cpu_ack`+`cpu_err` in cycle 1.
- **Latency, mapped:** select rises in cycle 1. If ack is seen in cycle k ≥ 1, `cpu_ack` is in cycle k+1. Minimum is 2 cycles.
- **Throughput:** the next request can be accepted in the cycle after RESP. The minimum period is 3 cycles for a mapped access.
- **Timeout counter:** cleared on entering WAIT, incremented each WAIT cycle without ack. When it equals TIMEOUT_CYCLES−1 with no ack, the next state is RESP with err=1 and the select drops.
  - Ack in that same cycle wins: the access completes normally with err=0.
- **Counter width:** $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.

## Configuration

- `IO_BUS_ROUTER_TIMEOUT_EN`:
  - Defined: the timeout counter and timeout error path are built as described above.
  - Undefined: no counter is built, `TIMEOUT_CYCLES` is unused, and WAIT persists until the selected ack arrives. Errors then come only from decode.

## Test plan

- **RAM read:** req, addr 0x0000_0000_0000_1000, `mem_ack` one cycle after `mem_sel` rises with `mem_rdata`=0xDEAD_BEEF → `cpu_ack` in cycle 3, rdata 0xDEAD_BEEF, err=0, `io_sel`=0 throughout.
- **IO write to slave 1:** addr 0xFFFF_C000_0000_8000, `io_ack[1]`=1 in the first select cycle → `io_sel`=3'b010 for one cycle, `bus_wdata` = `cpu_wdata`, `cpu_ack` in cycle 2, err=0.
- **Errors:**
  - addr 0x0000_4000_0000_4000 (non-canonical) → ack+err in cycle 1, no select.
  - addr 0xFFFF_C000_0000_0000 (page 0x100000000, unmapped) → same response.
- **Timeout:** with macro, TIMEOUT_CYCLES=4, slave 0 never acks → select high 4 cycles, then ack+err=1, rdata 0.
  - Repeat with ack in the 4th cycle → err=0.
  - Without macro, an ack at cycle 300 completes normally.
- **Reset mid-WAIT:** assert `rst` while `io_sel`=3'b001 → next cycle all selects 0, no `cpu_ack`. A subsequent RAM read then completes normally.
- **Stray ack:** `io_ack[2]` pulses while slave 0 is selected → ignored; completion occurs only on `io_ack[0]`.
